// File: rtl/dac_writer_if.sv
// Host handshake and SPI bus of dac_writer, bundled for module ports.
// master: the dac_writer side; slave: the host / DAC side.
interface dac_writer_if #(
  parameter int DATA_WID = 20
) ();
  logic [DATA_WID-1:0] data_in;
  logic                arm;
  logic                ready;
  logic                finished;
  logic [DATA_WID-1:0] readback;
  logic                readback_err;
  logic                sck;
  logic                mosi;
  logic                ss_L;
  logic                miso;

  modport master (
    input  data_in, arm, miso,
    output ready, finished, readback, readback_err, sck, mosi, ss_L
  );

  modport slave (
    output data_in, arm, miso,
    input  ready, finished, readback, readback_err, sck, mosi, ss_L
  );
endinterface

// File: rtl/dac_writer.sv
// SPI master (CPOL=0, CPHA=1, MSB first) writing a setpoint frame {4'b0001, data} to a DAC.
// Define DAC_WRITER_READBACK_EN to follow the write with read + NOP frames and capture readback.
module dac_writer #(
  parameter int WID      = 24,
  parameter int DATA_WID = 20,
  parameter int SCK_HALF = 2,
  parameter int SS_WAIT  = 2
) (
  input  logic         clk,
  input  logic         rst_L,
  dac_writer_if.master bus
);
  localparam int TMAX = (SCK_HALF > SS_WAIT) ? SCK_HALF : SS_WAIT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = (WID > 1) ? $clog2(WID) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_tick;
  logic [BW-1:0]  r_bit;
  logic           r_last;
  logic [WID-1:0] r_frame;
  logic           r_sck, r_mosi, r_ss_n, r_finished;
  logic           w_half_done, w_gap_done, w_accept, w_last_frame, w_frame_start;
  logic [WID-1:0] w_frame_nxt;

  function automatic logic [WID-1:0] build_frame(input logic [3:0] cmd,
                                                  input logic [DATA_WID-1:0] d);
    logic [WID-1:0] f;
    f = '0;
    f[DATA_WID-1:0] = d;
    f[WID-1 -: 4]   = cmd;
    return f;
  endfunction

  assign w_half_done   = (r_tick == TW'(SCK_HALF - 1));
  assign w_gap_done    = (r_tick == TW'(SS_WAIT - 1));
  assign w_accept      = (r_state == S_IDLE) && bus.arm;
  assign w_frame_start = w_accept || ((r_state == S_GAP) && w_gap_done && !w_last_frame);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.arm) w_state_nxt = S_SETUP;
      S_SETUP: if (w_half_done) w_state_nxt = S_SHIFT;
      // r_last marks that the falling edge of bit 0 has already happened
      S_SHIFT: if (w_half_done && !r_sck && r_last) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_half_done) w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_done) w_state_nxt = w_last_frame ? S_IDLE : S_SETUP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_tick     <= '0;
      r_bit      <= '0;
      r_last     <= 1'b0;
      r_frame    <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= 1'b1;
      r_finished <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      if ((w_state_nxt != r_state) || (r_state == S_IDLE) || ((r_state == S_SHIFT) && w_half_done))
        r_tick <= '0;
      else
        r_tick <= r_tick + TW'(1);

      if (w_frame_start) begin
        r_frame <= w_frame_nxt;
        r_bit   <= BW'(WID - 1);
        r_last  <= 1'b0;
        r_ss_n  <= 1'b0;
        r_sck   <= 1'b0;
        r_mosi  <= w_frame_nxt[WID-1];
      end

      case (r_state)
        S_SETUP: if (w_half_done) r_sck <= 1'b1;
        S_SHIFT: if (w_half_done) begin
          if (r_sck) begin
            r_sck <= 1'b0;
            if (r_bit == '0) r_last <= 1'b1;
            else             r_bit  <= r_bit - BW'(1);
          end else if (!r_last) begin
            r_sck  <= 1'b1;
            r_mosi <= r_frame[r_bit];
          end
        end
        S_HOLD: if (w_half_done) begin
          r_ss_n <= 1'b1;
          r_mosi <= 1'b0;
        end
        S_GAP: if (w_gap_done && w_last_frame) r_finished <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ready    = (r_state == S_IDLE);
  assign bus.finished = r_finished;
  assign bus.sck      = r_sck;
  assign bus.mosi     = r_mosi;
  assign bus.ss_L     = r_ss_n;

`ifdef DAC_WRITER_READBACK_EN
  logic [1:0]          r_fsel;
  logic [WID-1:0]      r_cap;
  logic [DATA_WID-1:0] r_readback;
  logic                r_rb_err;

  assign w_last_frame = (r_fsel == 2'd2);

  always_comb begin
    w_frame_nxt = '0;
    if (w_accept)            w_frame_nxt = build_frame(4'b0001, bus.data_in);
    else if (r_fsel == 2'd0) w_frame_nxt = build_frame(4'b1001, '0);
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_fsel     <= '0;
      r_cap      <= '0;
      r_readback <= '0;
      r_rb_err   <= 1'b0;
    end else begin
      if (w_accept)           r_fsel <= '0;
      else if (w_frame_start) r_fsel <= r_fsel + 2'd1;
      if ((r_state == S_SHIFT) && w_half_done && r_sck)
        r_cap <= {r_cap[WID-2:0], bus.miso};
      if ((r_state == S_GAP) && w_gap_done && w_last_frame) begin
        r_readback <= r_cap[DATA_WID-1:0];
        r_rb_err   <= (r_cap[WID-1 -: 4] != 4'b1001);
      end
    end
  end

  assign bus.readback     = r_readback;
  assign bus.readback_err = r_rb_err;
`else
  logic w_unused_miso;

  assign w_last_frame     = 1'b1;
  assign w_frame_nxt      = build_frame(4'b0001, bus.data_in);
  assign w_unused_miso    = bus.miso;
  assign bus.readback     = '0;
  assign bus.readback_err = 1'b0;
`endif
endmodule

// File: tb/tb_dac_writer.sv
// Bench for dac_writer: cycle-level behavioural model of bus/handshake timing derived from
// frame arithmetic, plus a DAC slave model that scoreboards every received frame.
module tb_dac_writer;
  localparam int WID = 24;
  localparam int DW  = 20;
  localparam int SH  = 2;
  localparam int SW  = 2;
`ifdef DAC_WRITER_READBACK_EN
  localparam int NF = 3;
  localparam int LAT_LIT = 307;
`else
  localparam int NF = 1;
  localparam int LAT_LIT = 103;
`endif
  localparam int FL   = SH * (2 * WID + 2) + SW;
  localparam int TOT  = NF * FL + 1;
  localparam int RCYC = 2000 * NF + 1000;

  logic clk = 1'b0;
  logic rst_L;

  dac_writer_if #(.DATA_WID(DW)) bus ();

  dac_writer #(.WID(WID), .DATA_WID(DW), .SCK_HALF(SH), .SS_WAIT(SW)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              cyc = 0;
  logic            m_busy = 1'b0;
  int              m_t = 0;
  logic [DW-1:0]   m_data = '0;
  logic [DW-1:0]   m_rb = '0;
  logic            m_err = 1'b0;
  logic [3:0]      rsp_prefix = 4'b1001;
  logic [WID-1:0]  exp_frames[$];

  function automatic logic [WID-1:0] frame_of(input int f, input logic [DW-1:0] d);
    if (f == 0) return {4'b0001, d};
    if (f == 1) return {4'b1001, 20'h00000};
    return '0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_L) begin
      m_busy = 1'b0; m_t = 0; m_rb = '0; m_err = 1'b0;
      exp_frames.delete();
    end else if (!m_busy || m_t == TOT) begin
      if (bus.arm) begin
        m_busy = 1'b1; m_t = 1; m_data = bus.data_in;
        for (int f = 0; f < NF; f++) exp_frames.push_back(frame_of(f, bus.data_in));
      end else begin
        m_busy = 1'b0; m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == TOT && NF == 3) begin
        m_rb  = m_data;
        m_err = (rsp_prefix != 4'b1001);
      end
    end
  end

  always @(posedge clk) begin
    int f, u, v;
    logic [WID-1:0] fr;
    logic e_ss, e_sck, e_mosi, e_rdy, e_fin;
    #1;
    e_ss = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_rdy = 1'b1; e_fin = 1'b0;
    if (rst_L && m_busy) begin
      if (m_t == TOT) e_fin = 1'b1;
      else begin
        f = (m_t - 1) / FL;
        u = (m_t - 1) % FL;
        fr = frame_of(f, m_data);
        e_rdy = 1'b0;
        if (u < SH) begin
          e_ss = 1'b0; e_mosi = fr[WID-1];
        end else if (u < SH + 2 * WID * SH) begin
          v = u - SH;
          e_ss = 1'b0;
          e_sck = ((v % (2 * SH)) < SH);
          e_mosi = fr[WID - 1 - v / (2 * SH)];
        end else if (u < 2 * SH + 2 * WID * SH) begin
          e_ss = 1'b0; e_mosi = fr[0];
        end
      end
    end
    check("ss_L", bus.ss_L, e_ss);
    check("sck", bus.sck, e_sck);
    check("mosi", bus.mosi, e_mosi);
    check("ready", bus.ready, e_rdy);
    check("finished", bus.finished, e_fin);
    check("readback", bus.readback, m_rb);
    check("readback_err", bus.readback_err, m_err);
  end

  // ---------------- DAC slave model ----------------
  logic [WID-1:0] s_rx = '0, s_rsp = '0, s_pending = '0, last_wr = '0;
  logic [DW-1:0]  curset = '0;
  logic           s_miso = 1'b0;
  int             s_bits = 0, s_idx = 0, sck_rises = 0;

  assign bus.miso = s_miso & ~bus.ss_L;

  always @(negedge bus.ss_L) begin
    s_rx = '0; s_bits = 0; s_rsp = s_pending; s_pending = '0; s_idx = WID - 1;
  end

  always @(posedge bus.sck) begin
    sck_rises++;
    s_miso = (s_idx >= 0) ? s_rsp[s_idx] : 1'b0;
    s_idx--;
  end

  always @(negedge bus.sck) begin
    if (!bus.ss_L) begin
      s_rx = {s_rx[WID-2:0], bus.mosi};
      s_bits++;
    end
  end

  always @(posedge bus.ss_L) begin
    if (rst_L) begin
      check("frame_bits", s_bits, WID);
      check("frame_expected", exp_frames.size() > 0, 1);
      if (exp_frames.size() > 0) check("frame", s_rx, exp_frames.pop_front());
      if (s_rx[WID-1 -: 4] == 4'b0001) begin
        curset = s_rx[DW-1:0];
        last_wr = s_rx;
      end
      if (s_rx[WID-1 -: 4] == 4'b1001) s_pending = {rsp_prefix, curset};
    end else begin
      s_pending = '0;
    end
  end

  int run = 0, last_gap = 0;
  always @(posedge clk) begin
    #1;
    if (bus.ss_L) run++;
    else begin
      if (run > 0) last_gap = run;
      run = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_fin(input int start, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.finished) begin
        lat = cyc - start;
        return;
      end
    end
    check("finished_timeout", bus.finished, 1);
  endtask

  task automatic arm_pulse(input logic [DW-1:0] d, output int start);
    @(negedge clk);
    bus.data_in = d; bus.arm = 1'b1; start = cyc;
    @(negedge clk);
    bus.arm = 1'b0; bus.data_in = ~d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, lat, k, s0, nfin;
    rst_L = 1'b1; bus.arm = 1'b0; bus.data_in = '0;
    #2 rst_L = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_ss_L", bus.ss_L, 1);
    check("rst_sck", bus.sck, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_finished", bus.finished, 0);
    check("rst_readback", bus.readback, 0);
    check("rst_readback_err", bus.readback_err, 0);
    rst_L = 1'b1;

    // single write, data changed after accept
    arm_pulse(20'hABCDE, a);
    wait_fin(a, TOT + 50, lat);
    check("latency", lat, LAT_LIT);
    repeat (2) @(negedge clk);
    check("write_frame", last_wr, 24'h1ABCDE);
    check("curset", curset, 20'hABCDE);

`ifdef DAC_WRITER_READBACK_EN
    arm_pulse(20'h12345, a);
    wait_fin(a, TOT + 50, lat);
    check("rb_value", bus.readback, 20'h12345);
    check("rb_err_clear", bus.readback_err, 0);
    @(negedge clk);
    rsp_prefix = 4'b0000;
    arm_pulse(20'h0F0F0, a);
    wait_fin(a, TOT + 50, lat);
    check("rb_err_set", bus.readback_err, 1);
    check("rb_value2", bus.readback, 20'h0F0F0);
    @(negedge clk);
    rsp_prefix = 4'b1001;
`endif

    // reset at the 10th sck pulse
    @(negedge clk);
    s0 = sck_rises;
    arm_pulse(20'hFFFFF, a);
    k = 0;
    while ((sck_rises - s0) < 10 && k < 200) begin
      @(negedge clk); k++;
    end
    check("sck10_reached", sck_rises - s0, 10);
    check("sck10_high", bus.sck, 1);
    rst_L = 1'b0;
    #1;
    check("abort_sck", bus.sck, 0);
    check("abort_ss_L", bus.ss_L, 1);
    check("abort_finished", bus.finished, 0);
    check("abort_ready", bus.ready, 1);
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    nfin = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (bus.finished) nfin++;
    end
    check("abort_no_finished", nfin, 0);
    arm_pulse(20'h00001, a);
    wait_fin(a, TOT + 50, lat);
    repeat (2) @(negedge clk);
    check("rearm_curset", curset, 20'h00001);

    // arm held high: back-to-back transactions, mid-frame arm ignored
    @(negedge clk);
    bus.data_in = 20'h00010; bus.arm = 1'b1; a = cyc;
    @(negedge clk);
    bus.data_in = 20'h00020;
    wait_fin(a, TOT + 50, lat);
    @(negedge clk);
    @(negedge clk);
    bus.arm = 1'b0;
    check("b2b_busy", bus.ready, 0);
    check("b2b_gap", last_gap, 3);
    repeat (30) @(negedge clk);
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
    wait_fin(cyc, TOT + 50, lat);
    repeat (20) @(negedge clk);
    check("b2b_idle_ss_L", bus.ss_L, 1);
    check("b2b_idle_ready", bus.ready, 1);
    check("b2b_curset", curset, 20'h00020);

    // randomized arm/data traffic
    for (int i = 0; i < RCYC; i++) begin
      @(negedge clk);
      bus.arm = ($urandom_range(0, 5) == 0);
      bus.data_in = DW'($urandom);
    end
    bus.arm = 1'b0;
    k = 0;
    while (m_busy && k < TOT + 50) begin
      @(negedge clk); k++;
    end
    repeat (2) @(negedge clk);
    check("drain_ready", bus.ready, 1);
    check("frames_left", exp_frames.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
